crypt_clk_req_ctrl: RTL and testbench
=====================================

// Module: crypt_clk_req_ctrl
// PURPOSE
//  Requester side of the encryption-engine clock-gating interface. Arbitrates crypto
//  service requests from the TX and RX controllers and raises clock requests towards
//  the crypto clock controller. Waits for the returned clock enables and a settle
//  delay before granting the engine. Keeps clocks requested for a hysteresis window
//  after each job, so back-to-back MPDUs avoid a re-wake.
// PARAMETERS
//  WAKE_DLY   2   settle cycles between enables seen high and grant (0 = no settle)
//  IDLE_HOLD  8   cycles clocks stay requested after a job ends (>=1)
//  CNT_W      4   shared counter width; must hold max(WAKE_DLY, IDLE_HOLD)
// PORTS
//  macCoreClk       in   1  MAC core clock
//  macCoreClkRst    in   1  reset, synchronous, active-high
//  txCryptReq       in   1  TX controller needs the engine (level)
//  txCipherType     in   3  TX cipher: 0 none, 1 WEP, 2 TKIP, 3 CCMP, 4 WAPI
//  rxCryptReq       in   1  RX controller needs the engine (level)
//  rxCipherType     in   3  RX cipher, same coding
//  cryptDone_p      in   1  engine finished current job (1-cycle pulse)
//  macCryptClkEn    in   1  crypt clock enable returned by the clock controller
//  macWTClkEn       in   1  WEP/TKIP fast clock enable returned by the clock controller
//  activeClkGating  in   1  SW active clock gating enable
//  cryptClkReq      out  1  request crypt clock
//  cryptWTClkReq    out  1  request WEP/TKIP fast clock
//  txCryptGnt       out  1  engine granted to TX
//  rxCryptGnt       out  1  engine granted to RX
//  cryptCipherType  out  3  cipher latched for the current or last owner
//  cryptBusy        out  1  state is WAKE, SETTLE or GRANT
// BEHAVIOUR
//  - Reset (synchronous): state IDLE, counter 0, owner none, every output 0, cryptCipherType 0.
//    A reset mid-job clears grants and clock requests on the next edge.
//  - Outputs are Moore-decoded from registered state, owner and needWT.
//  - cryptClkReq = state != IDLE.
//  - cryptWTClkReq = cryptClkReq && needWT.
//  - needWT is latched at acceptance: cipher 1 or 2.
//  - FSM IDLE:
//    - rxCryptReq has priority over txCryptReq when both are high.
//    - On acceptance, latch owner, cryptCipherType and needWT.
//    - cipher 0, or activeClkGating = 0: go to GRANT.
//    - otherwise: go to WAKE.
//  - FSM WAKE:
//    - Wait for macCryptClkEn, and also macWTClkEn when needWT.
//    - Then go to SETTLE and load the counter with WAKE_DLY-1.
//    - With WAKE_DLY = 0, go straight to GRANT.
//  - FSM SETTLE: count down; at 0 go to GRANT.
//  - FSM GRANT:
//    - Raise the owner's grant only.
//    - cryptDone_p, or owner request deasserted (abort): go to HOLD and load IDLE_HOLD-1.
//  - FSM HOLD:
//    - Counter at 0 with no request: go to IDLE.
//    - New request (RX priority): latch as in IDLE.
//      - Needs WT but WT was not requested, and activeClkGating = 1: go to WAKE.
//      - Otherwise go to GRANT; the settle delay is skipped.
//  - Abort in WAKE/SETTLE (owner request drops): go to HOLD. No grant is ever issued for that request.
//  - Latency from the request first seen high in IDLE (state IDLE that cycle):
//    - grant = 1 cycle when bypassed;
//    - grant = 2+WAKE_DLY cycles when enables are already high;
//    - each cycle the enables are low in WAKE adds one cycle.
//  - Grant lasts at least 1 cycle. cryptDone_p in the first GRANT cycle is honoured.
//    cryptDone_p outside GRANT is ignored.
//  - TX and RX grants are never high together. A grant never changes owner without passing through HOLD.
//  - The counter saturates at 0 and never wraps.
//  - activeClkGating changes take effect only at the next acceptance decision.
// STRUCTURE
//  - Shared package crypt_clk_pkg:
//    - state encoding IDLE/WAKE/SETTLE/GRANT/HOLD;
//    - cipher constants CIPHER_NONE/WEP/TKIP/CCMP/WAPI;
//    - function needsWT(cipher).
//  - One sub-module, crypt_clk_dly_cnt: loadable CNT_W down-counter with zero flag, used for SETTLE and HOLD.
// TESTING
//  1. Gating on, enables high, WAKE_DLY=2, rxCryptReq=1, cipher=3 at cycle 0:
//     cryptClkReq=1 at cycle 1; rxCryptGnt=1 at cycle 4; cryptWTClkReq stays 0.
//  2. txCryptReq=1 with cipher=2, macWTClkEn held low for 5 cycles:
//     state stays WAKE for 5 cycles; txCryptGnt only after enable + 2 settle cycles.
//  3. tx and rx requests in the same cycle:
//     rxCryptGnt first. After cryptDone_p, HOLD, then txCryptGnt 1 cycle later with no re-wake.
//  4. Job done, no further request, IDLE_HOLD=8:
//     cryptClkReq stays high 8 cycles after the done cycle, then 0; cryptBusy=0 throughout.
//  5. activeClkGating=0 or cipher=0:
//     grant on the cycle after the request. Request dropped during SETTLE: no grant, go to HOLD.
//  6. macCoreClkRst=1 during GRANT:
//     all outputs 0 on the next edge; the pending request is re-arbitrated from IDLE after reset.

Source files
------------

// File: rtl/crypt_clk_pkg.sv
// ---------------------------------------------------------------------------
// crypt_clk_pkg
// Shared definitions for the crypto clock-request controller:
//   - cryptState_t  : requester FSM states IDLE/WAKE/SETTLE/GRANT/HOLD
//   - cryptOwner_t  : which controller currently owns (or last owned) the engine
//   - CIPHER_*      : cipher type coding used on the TX/RX cipher buses
//   - needsWT()     : true for ciphers that run on the WEP/TKIP fast clock
// ---------------------------------------------------------------------------
package crypt_clk_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAKE   = 3'd1,
    SETTLE = 3'd2,
    GRANT  = 3'd3,
    HOLD   = 3'd4
  } cryptState_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_TX   = 2'd1,
    OWNER_RX   = 2'd2
  } cryptOwner_t;

  localparam logic [2:0] CIPHER_NONE = 3'd0;
  localparam logic [2:0] CIPHER_WEP  = 3'd1;
  localparam logic [2:0] CIPHER_TKIP = 3'd2;
  localparam logic [2:0] CIPHER_CCMP = 3'd3;
  localparam logic [2:0] CIPHER_WAPI = 3'd4;

  // WEP and TKIP are the only ciphers that need the fast WT clock.
  function automatic logic needsWT(input logic [2:0] cipher);
    return (cipher == CIPHER_WEP) || (cipher == CIPHER_TKIP);
  endfunction

endpackage

// File: rtl/crypt_clk_dly_cnt.sv
// ---------------------------------------------------------------------------
// crypt_clk_dly_cnt
// Loadable down-counter with zero flag. Used by the requester FSM both for
// the settle delay and for the idle hysteresis window.
// Ports:
//   macCoreClk     in   MAC core clock
//   macCoreClkRst  in   synchronous active-high reset
//   load           in   load loadVal this cycle (wins over dec)
//   loadVal        in   value to load
//   dec            in   decrement by one, saturating at zero
//   zero           out  counter currently holds zero
// ---------------------------------------------------------------------------
module crypt_clk_dly_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             macCoreClk,
  input  logic             macCoreClkRst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Count register: load has priority; decrement stops at zero so the
  // counter can never wrap back to its maximum.
  always_ff @(posedge macCoreClk) begin
    if (macCoreClkRst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/crypt_clk_req_ctrl.sv
// ---------------------------------------------------------------------------
// crypt_clk_req_ctrl
// Requester side of the encryption-engine clock-gating interface. Arbitrates
// TX/RX crypto requests (RX wins ties), requests the crypt and WEP/TKIP clocks,
// waits for the returned enables plus a settle delay, then grants the engine.
// Clocks stay requested for a hysteresis window after each job so that a
// back-to-back MPDU can be granted without re-waking the clocks.
// Ports:
//   macCoreClk, macCoreClkRst        clock, synchronous active-high reset
//   txCryptReq/txCipherType          TX request level and cipher
//   rxCryptReq/rxCipherType          RX request level and cipher
//   cryptDone_p                      engine job finished (pulse)
//   macCryptClkEn, macWTClkEn        enables returned by clock controller
//   activeClkGating                  SW enable for clock gating
//   cryptClkReq, cryptWTClkReq       clock requests
//   txCryptGnt, rxCryptGnt           engine grants
//   cryptCipherType                  cipher of current/last owner
//   cryptBusy                        WAKE, SETTLE or GRANT
// ---------------------------------------------------------------------------
module crypt_clk_req_ctrl
  import crypt_clk_pkg::*;
#(
  parameter int WAKE_DLY  = 2,
  parameter int IDLE_HOLD = 8,
  parameter int CNT_W     = 4
) (
  input  logic       macCoreClk,
  input  logic       macCoreClkRst,
  input  logic       txCryptReq,
  input  logic [2:0] txCipherType,
  input  logic       rxCryptReq,
  input  logic [2:0] rxCipherType,
  input  logic       cryptDone_p,
  input  logic       macCryptClkEn,
  input  logic       macWTClkEn,
  input  logic       activeClkGating,
  output logic       cryptClkReq,
  output logic       cryptWTClkReq,
  output logic       txCryptGnt,
  output logic       rxCryptGnt,
  output logic [2:0] cryptCipherType,
  output logic       cryptBusy
);

  localparam int SETTLE_INT = (WAKE_DLY > 0) ? WAKE_DLY - 1 : 0;
  localparam int HOLD_INT   = (IDLE_HOLD > 0) ? IDLE_HOLD - 1 : 0;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = SETTLE_INT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] HOLD_LOAD   = HOLD_INT[CNT_W-1:0];

  cryptState_t      state, stateNext;
  cryptOwner_t      owner, ownerNext;
  logic [2:0]       cipherReg, cipherNext;
  logic             needWT, needWTNext;
  logic             cntLoad, cntDec, cntZero;
  logic [CNT_W-1:0] cntLoadVal;

  logic             anyReq, ownerReq, enablesOk;
  logic [2:0]       selCipher;
  cryptOwner_t      selOwner;

  // Arbitration view of the inputs: RX wins when both request, and the
  // owner's own request level is what decides an abort.
  assign anyReq    = txCryptReq | rxCryptReq;
  assign selOwner  = rxCryptReq ? OWNER_RX : OWNER_TX;
  assign selCipher = rxCryptReq ? rxCipherType : txCipherType;
  assign ownerReq  = (owner == OWNER_RX) ? rxCryptReq :
                     (owner == OWNER_TX) ? txCryptReq : 1'b0;
  assign enablesOk = macCryptClkEn && (!needWT || macWTClkEn);

  // Shared delay counter for the settle delay and the hold window.
  crypt_clk_dly_cnt #(.CNT_W(CNT_W)) uDlyCnt (
    .macCoreClk    (macCoreClk),
    .macCoreClkRst (macCoreClkRst),
    .load          (cntLoad),
    .loadVal       (cntLoadVal),
    .dec           (cntDec),
    .zero          (cntZero)
  );

  // State register plus the owner/cipher/needWT context latched at acceptance.
  always_ff @(posedge macCoreClk) begin
    if (macCoreClkRst) begin
      state     <= IDLE;
      owner     <= OWNER_NONE;
      cipherReg <= CIPHER_NONE;
      needWT    <= 1'b0;
    end else begin
      state     <= stateNext;
      owner     <= ownerNext;
      cipherReg <= cipherNext;
      needWT    <= needWTNext;
    end
  end

  // Next-state logic. Acceptance happens in IDLE and HOLD; from HOLD the
  // clocks are already running so only a missing WT clock forces a re-wake.
  always_comb begin
    stateNext  = state;
    ownerNext  = owner;
    cipherNext = cipherReg;
    needWTNext = needWT;
    cntLoad    = 1'b0;
    cntLoadVal = '0;
    cntDec     = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) begin
          ownerNext  = selOwner;
          cipherNext = selCipher;
          needWTNext = needsWT(selCipher);
          if ((selCipher == CIPHER_NONE) || !activeClkGating) begin
            stateNext = GRANT;
          end else begin
            stateNext = WAKE;
          end
        end
      end
      WAKE: begin
        if (!ownerReq) begin
          stateNext  = HOLD;
          cntLoad    = 1'b1;
          cntLoadVal = HOLD_LOAD;
        end else if (enablesOk) begin
          if (WAKE_DLY == 0) begin
            stateNext = GRANT;
          end else begin
            stateNext  = SETTLE;
            cntLoad    = 1'b1;
            cntLoadVal = SETTLE_LOAD;
          end
        end
      end
      SETTLE: begin
        if (!ownerReq) begin
          stateNext  = HOLD;
          cntLoad    = 1'b1;
          cntLoadVal = HOLD_LOAD;
        end else if (cntZero) begin
          stateNext = GRANT;
        end else begin
          cntDec = 1'b1;
        end
      end
      GRANT: begin
        if (cryptDone_p || !ownerReq) begin
          stateNext  = HOLD;
          cntLoad    = 1'b1;
          cntLoadVal = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (anyReq) begin
          ownerNext  = selOwner;
          cipherNext = selCipher;
          needWTNext = needsWT(selCipher);
          if (needsWT(selCipher) && !needWT && activeClkGating) begin
            stateNext = WAKE;
          end else begin
            stateNext = GRANT;
          end
        end else if (cntZero) begin
          stateNext = IDLE;
        end else begin
          cntDec = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Moore output decode from the registered state and context.
  assign cryptClkReq     = (state != IDLE);
  assign cryptWTClkReq   = cryptClkReq && needWT;
  assign txCryptGnt      = (state == GRANT) && (owner == OWNER_TX);
  assign rxCryptGnt      = (state == GRANT) && (owner == OWNER_RX);
  assign cryptBusy       = (state == WAKE) || (state == SETTLE) || (state == GRANT);
  assign cryptCipherType = cipherReg;

endmodule

// File: tb/tb_crypt_clk_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_crypt_clk_req_ctrl
// Directed bench for crypt_clk_req_ctrl with WAKE_DLY=2, IDLE_HOLD=8.
// Inputs change just after a falling edge, outputs are sampled on the
// falling edge, so "cycle N" below means the Nth falling edge after the
// request was first presented.
// ---------------------------------------------------------------------------
module tb_crypt_clk_req_ctrl;
  import crypt_clk_pkg::*;

  logic       macCoreClk;
  logic       macCoreClkRst;
  logic       txCryptReq;
  logic [2:0] txCipherType;
  logic       rxCryptReq;
  logic [2:0] rxCipherType;
  logic       cryptDone_p;
  logic       macCryptClkEn;
  logic       macWTClkEn;
  logic       activeClkGating;
  logic       cryptClkReq;
  logic       cryptWTClkReq;
  logic       txCryptGnt;
  logic       rxCryptGnt;
  logic [2:0] cryptCipherType;
  logic       cryptBusy;

  int checkCount;
  int failCount;

  crypt_clk_req_ctrl #(.WAKE_DLY(2), .IDLE_HOLD(8), .CNT_W(4)) dut (
    .macCoreClk      (macCoreClk),
    .macCoreClkRst   (macCoreClkRst),
    .txCryptReq      (txCryptReq),
    .txCipherType    (txCipherType),
    .rxCryptReq      (rxCryptReq),
    .rxCipherType    (rxCipherType),
    .cryptDone_p     (cryptDone_p),
    .macCryptClkEn   (macCryptClkEn),
    .macWTClkEn      (macWTClkEn),
    .activeClkGating (activeClkGating),
    .cryptClkReq     (cryptClkReq),
    .cryptWTClkReq   (cryptWTClkReq),
    .txCryptGnt      (txCryptGnt),
    .rxCryptGnt      (rxCryptGnt),
    .cryptCipherType (cryptCipherType),
    .cryptBusy       (cryptBusy)
  );

  // Free-running 10-unit clock.
  initial macCoreClk = 1'b0;
  always #5 macCoreClk = ~macCoreClk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Checks the five single-bit outputs in one go.
  task automatic checkOuts(input string tag, input logic clkReq, input logic wtReq,
                           input logic txG, input logic rxG, input logic busy);
    checkOutput({tag, ".clkReq"}, 32'(cryptClkReq), 32'(clkReq));
    checkOutput({tag, ".wtReq"},  32'(cryptWTClkReq), 32'(wtReq));
    checkOutput({tag, ".txGnt"},  32'(txCryptGnt), 32'(txG));
    checkOutput({tag, ".rxGnt"},  32'(rxCryptGnt), 32'(rxG));
    checkOutput({tag, ".busy"},   32'(cryptBusy), 32'(busy));
  endtask

  task automatic checkState(input string tag, input cryptState_t expState);
    checkOutput({tag, ".state"}, 32'(dut.state), 32'(expState));
  endtask

  // Drives the request/done inputs together.
  task automatic applyStimulus(input logic rxReq, input logic [2:0] rxCiph,
                               input logic txReq, input logic [2:0] txCiph,
                               input logic done);
    rxCryptReq   = rxReq;
    rxCipherType = rxCiph;
    txCryptReq   = txReq;
    txCipherType = txCiph;
    cryptDone_p  = done;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge macCoreClk);
  endtask

  initial begin
    checkCount      = 0;
    failCount       = 0;
    macCoreClkRst   = 1'b1;
    activeClkGating = 1'b1;
    macCryptClkEn   = 1'b1;
    macWTClkEn      = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick(2);
    checkOuts("reset", 0, 0, 0, 0, 0);
    checkOutput("reset.cipher", 32'(cryptCipherType), 32'd0);
    macCoreClkRst = 1'b0;
    tick(1);
    checkOuts("idle", 0, 0, 0, 0, 0);

    // RX CCMP with enables already high: grant at cycle 4, no WT request.
    applyStimulus(1'b1, 3'd3, 1'b0, 3'd0, 1'b0);
    tick(1);
    checkOuts("t1c1", 1, 0, 0, 0, 1);
    checkState("t1c1", WAKE);
    tick(1);
    checkOuts("t1c2", 1, 0, 0, 0, 1);
    checkState("t1c2", SETTLE);
    tick(1);
    checkOuts("t1c3", 1, 0, 0, 0, 1);
    tick(1);
    checkOuts("t1c4", 1, 0, 0, 1, 1);
    checkOutput("t1c4.cipher", 32'(cryptCipherType), 32'd3);

    // Job done at cycle 4, no further request: clocks held for 8 cycles.
    applyStimulus(1'b0, 3'd3, 1'b0, 3'd0, 1'b1);
    tick(1);
    checkOuts("t4hold5", 1, 0, 0, 0, 0);
    applyStimulus(1'b0, 3'd3, 1'b0, 3'd0, 1'b0);
    for (int i = 6; i <= 12; i++) begin
      tick(1);
      checkOuts($sformatf("t4hold%0d", i), 1, 0, 0, 0, 0);
    end
    tick(1);
    checkOuts("t4idle", 0, 0, 0, 0, 0);
    checkOutput("t4idle.cipher", 32'(cryptCipherType), 32'd3);

    // TX TKIP with the WT enable held low for the first 5 WAKE cycles.
    macWTClkEn = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b1, 3'd2, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      checkState($sformatf("t2wake%0d", i), WAKE);
      checkOuts($sformatf("t2wake%0d", i), 1, 1, 0, 0, 1);
    end
    macWTClkEn = 1'b1;
    tick(1);
    checkState("t2c6", SETTLE);
    checkOutput("t2c6.txGnt", 32'(txCryptGnt), 32'd0);
    tick(1);
    checkOutput("t2c7.txGnt", 32'(txCryptGnt), 32'd0);
    tick(1);
    checkOuts("t2c8", 1, 1, 1, 0, 1);
    checkOutput("t2c8.cipher", 32'(cryptCipherType), 32'd2);
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
    tick(1);
    checkOuts("t2hold", 1, 1, 0, 0, 0);
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd2, 1'b0);
    tick(8);
    checkOuts("t2idle", 0, 0, 0, 0, 0);

    // Simultaneous RX CCMP and TX WAPI: RX first, TX straight from HOLD.
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd4, 1'b0);
    tick(3);
    checkOuts("t3c3", 1, 0, 0, 0, 1);
    tick(1);
    checkOuts("t3c4", 1, 0, 0, 1, 1);
    applyStimulus(1'b0, 3'd3, 1'b1, 3'd4, 1'b1);
    tick(1);
    checkOuts("t3hold", 1, 0, 0, 0, 0);
    checkState("t3hold", HOLD);
    applyStimulus(1'b0, 3'd3, 1'b1, 3'd4, 1'b0);
    tick(1);
    checkOuts("t3tx", 1, 0, 1, 0, 1);
    checkOutput("t3tx.cipher", 32'(cryptCipherType), 32'd4);

    // Back-to-back TX WEP after WAPI: WT never requested, so re-wake from HOLD.
    applyStimulus(1'b0, 3'd3, 1'b1, 3'd1, 1'b1);
    tick(1);
    checkOuts("t3bHold", 1, 0, 0, 0, 0);
    applyStimulus(1'b0, 3'd3, 1'b1, 3'd1, 1'b0);
    tick(1);
    checkState("t3bWake", WAKE);
    checkOuts("t3bWake", 1, 1, 0, 0, 1);
    tick(2);
    checkOutput("t3bC10.txGnt", 32'(txCryptGnt), 32'd0);
    tick(1);
    checkOuts("t3bGnt", 1, 1, 1, 0, 1);
    checkOutput("t3bGnt.cipher", 32'(cryptCipherType), 32'd1);
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick(8);
    checkOuts("t3bIdle", 0, 0, 0, 0, 0);

    // Gating off: RX CCMP granted on the next cycle, then aborted.
    activeClkGating = 1'b0;
    applyStimulus(1'b1, 3'd3, 1'b0, 3'd0, 1'b0);
    tick(1);
    checkOuts("t5aGnt", 1, 0, 0, 1, 1);
    applyStimulus(1'b0, 3'd3, 1'b0, 3'd0, 1'b0);
    tick(1);
    checkOuts("t5aAbort", 1, 0, 0, 0, 0);
    tick(8);
    checkOuts("t5aIdle", 0, 0, 0, 0, 0);

    // Gating on, cipher none: bypass, grant on the next cycle.
    activeClkGating = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b1, 3'd0, 1'b0);
    tick(1);
    checkOuts("t5bGnt", 1, 0, 1, 0, 1);
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick(8);
    checkOuts("t5bIdle", 0, 0, 0, 0, 0);

    // Request dropped during SETTLE: HOLD, never granted.
    applyStimulus(1'b0, 3'd0, 1'b1, 3'd3, 1'b0);
    tick(2);
    checkState("t5cSettle", SETTLE);
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd3, 1'b0);
    tick(1);
    checkState("t5cHold", HOLD);
    checkOuts("t5cHold", 1, 0, 0, 0, 0);
    tick(1);
    checkOuts("t5cHold2", 1, 0, 0, 0, 0);
    tick(7);
    checkOuts("t5cIdle", 0, 0, 0, 0, 0);

    // Reset during GRANT, request still pending: re-arbitrated from IDLE.
    applyStimulus(1'b1, 3'd3, 1'b0, 3'd0, 1'b0);
    tick(4);
    checkOuts("t6Gnt", 1, 0, 0, 1, 1);
    macCoreClkRst = 1'b1;
    tick(1);
    checkOuts("t6Rst", 0, 0, 0, 0, 0);
    checkOutput("t6Rst.cipher", 32'(cryptCipherType), 32'd0);
    macCoreClkRst = 1'b0;
    tick(1);
    checkOuts("t6c1", 1, 0, 0, 0, 1);
    tick(3);
    checkOuts("t6c4", 1, 0, 0, 1, 1);
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
